// File: rtl/control_out_capture.sv
// Control-word capture: round-robin arbitration over N_CH producers into a single
// FIFO, with an optional per-channel "store only on change" filter.
module control_out_capture #(
   parameter int DATA_W = 32,
   parameter int N_CH   = 2,
   parameter int DEPTH  = 8,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     mode_change_only,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic [CNT_W-1:0]         count,
   output logic [15:0]              filt_cnt
);

   // Handshakes: a word moves when valid & ready are both high at a rising edge.
   // in_ready is a one-hot-or-zero grant that never depends on out_ready, so a full
   // FIFO never accepts a write in the same cycle as a pop; out_valid is high
   // exactly while the FIFO holds data, and the head is held until out_ready.

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [CH_W-1:0]   mem_ch   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CH_W-1:0]   rr_ptr, grant_idx, rr_next;
   logic [CH_W:0]     idx;
   logic [N_CH-1:0]   grant;
   logic              found;
   logic [N_CH-1:0]   last_vld;
   logic [DATA_W-1:0] last_val [N_CH];
   logic [DATA_W-1:0] word;
   logic              can_accept, xfer, filtered, push, pop;

   // Round-robin search beginning at rr_ptr, wrapping past the last channel.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = {1'b0, rr_ptr} + (CH_W + 1)'(k);
         if (idx >= (CH_W + 1)'(N_CH)) idx = idx - (CH_W + 1)'(N_CH);
         if (!found && in_valid[idx[CH_W-1:0]]) begin
            found                 = 1'b1;
            grant_idx             = idx[CH_W-1:0];
            grant[idx[CH_W-1:0]]  = 1'b1;
         end
      end
   end

   assign can_accept = !rst_n && !clear && (count != CNT_W'(DEPTH));
   assign in_ready   = can_accept ? grant : '0;
   assign xfer       = |(in_valid & in_ready);
   assign word       = in_data[grant_idx*DATA_W +: DATA_W];
   assign filtered   = mode_change_only && last_vld[grant_idx] && (last_val[grant_idx] == word);
   assign push       = xfer && !filtered;
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready && !clear;
   assign rr_next    = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

   assign out_data = mem_data[rd_ptr];
   assign out_ch   = mem_ch[rd_ptr];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         filt_cnt <= '0;
         rr_ptr   <= '0;
         last_vld <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         filt_cnt <= '0;
         rr_ptr   <= '0;
         last_vld <= '0;
      end else begin
         if (xfer) begin
            rr_ptr              <= rr_next;
            last_vld[grant_idx] <= 1'b1;
         end
         if (xfer && filtered && (filt_cnt != 16'hFFFF)) filt_cnt <= filt_cnt + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity lives entirely in count and last_vld.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= word;
         mem_ch[wr_ptr]   <= grant_idx;
      end
      if (xfer) last_val[grant_idx] <= word;
   end

endmodule

// File: doc/control_out_capture.md
CONTROL_OUT_CAPTURE -- requirements
Module: control_out_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning control word width in bits.
REQ-002 SHALL have parameter N_CH, default 2, meaning number of control-word producer channels (1..8).
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of 2, >= 2).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous reset, active-high (asserted = 1).
REQ-006 SHALL have port: clear  in  1  synchronous flush of FIFO, counters, last-value state.
REQ-007 SHALL have port: mode_change_only  in  1  1 = store only words differing from that channel's previous accepted word.
REQ-008 SHALL have port: in_valid  in  N_CH  per-channel word offered.
REQ-009 SHALL have port: in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port: in_ready  out  N_CH  one-hot-or-zero grant; transfer on in_valid[i] & in_ready[i].
REQ-011 SHALL have port: out_valid  out  1  FIFO head valid.
REQ-012 SHALL have port: out_ready  in  1  consumer accepts head.
REQ-013 SHALL have port: out_data  out  DATA_W  head word.
REQ-014 SHALL have port: out_ch  out  max(1,clog2(N_CH))  source channel of head word.
REQ-015 SHALL have port: count  out  clog2(DEPTH+1)  current occupancy.
REQ-016 SHALL have port: filt_cnt  out  16  words discarded by change-only filter, saturating.

Function
REQ-017 SHALL grant at most one channel per cycle, round-robin: search starts at channel after last granted, wraps N_CH-1 -> 0; initial pointer after reset/clear = 0.
REQ-018 SHALL drive in_ready = 0 for all channels when count == DEPTH, regardless of out_ready (no write-through when full).
REQ-019 SHALL drive in_ready = 0 for all channels while clear = 1.
REQ-020 SHALL, on transfer from channel i with mode_change_only = 0, write {i, word} at tail next edge.
REQ-021 SHALL, on transfer with mode_change_only = 1, write only if channel i has no previous accepted word or word != last word; otherwise discard and increment filt_cnt (hold at 0xFFFF).
REQ-022 SHALL update channel i's last-value register on every transfer, stored or filtered.
REQ-023 SHALL pop head on out_valid & out_ready; out_valid = (count != 0), no bubble between back-to-back entries.
REQ-024 SHALL allow simultaneous push and pop when not full: count unchanged, order preserved.
REQ-025 SHALL make write-to-out_valid latency 1 cycle (word written at edge N visible at head after edge N when FIFO was empty).
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count derived exactly, never exceeds DEPTH or underflows.
REQ-027 SHALL hold out_data/out_ch stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL, on clear = 1 at an edge, empty FIFO, zero filt_cnt, invalidate all last-value registers, reset RR pointer; a pop requested that cycle is discarded.
REQ-029 SHALL treat out_data/out_ch as don't-care when out_valid = 0.

Reset
REQ-030 SHALL, while rst_n = 1, force asynchronously: count = 0, out_valid = 0, in_ready = 0, filt_cnt = 0, RR pointer = 0, all last-value registers invalid.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-transfer loses all FIFO content.

Verification
REQ-032 Both channels valid continuously (ch0 = 0x11, ch1 = 0x22), out_ready = 1 -> out stream alternates ch0, ch1, ch0, ...; count stays <= 1.
REQ-033 out_ready = 0, ch0 pushes 0x1..0x9 with DEPTH = 8 -> 8 accepted, count = 8, in_ready = 0 on 9th; then out_ready = 1 -> 0x1..0x8 in order, 0x9 accepted on first non-full cycle.
REQ-034 mode_change_only = 1, ch1 sends 0xA, 0xA, 0xB, 0xB, 0xA -> stored 0xA, 0xB, 0xA; filt_cnt = 2.
REQ-035 Full FIFO, out_ready = 1 and ch0 valid same cycle -> pop occurs, in_ready[0] = 0 that cycle, write next cycle, count 8 -> 7 -> 8.
REQ-036 FIFO holding 5 words, filt_cnt = 3, assert clear one cycle -> count = 0, filt_cnt = 0, out_valid = 0 next cycle; then repeated word after clear is stored (not filtered).
REQ-037 Assert rst_n with FIFO half full between clock edges -> outputs reach reset values immediately without a clk edge.
